decode_issue_ctrl: RTL and testbench
====================================

// Module: decode_issue_ctrl
// PURPOSE
//  Decode/issue controller between the IF/ID register and the EX stage of the 5-stage RV32I core.
//  - Decodes opcode to imm_sel_t, drives the immediate generator, and builds the EX control bundle.
//  - Registers the result into the ID->EX pipeline register with a valid/ready handshake.
//  - Inserts one bubble on a load-use hazard; drops its content on a pipeline flush.
// PARAMETERS
//  XLEN        32   datapath width (from defs; not overridable)
//  REG_AW       5   register-index width
// PORTS
//  clk_i          in    1      clock
//  rst_ni         in    1      asynchronous reset, active-low
//  flush_i        in    1      EX redirect (taken branch/jump); kill ID->EX contents
//  if_valid_i     in    1      IF/ID holds an instruction
//  if_ready_o     out   1      this block accepts the IF/ID instruction this cycle
//  if_instr_i     in    XLEN   raw instruction
//  if_pc_i        in    XLEN   PC of that instruction
//  ex_valid_o     out   1      ID->EX register holds a valid instruction
//  ex_ready_i     in    1      EX consumes the register this cycle
//  ex_pc_o        out   XLEN   registered PC
//  ex_rs1_o       out   REG_AW source register 1 index
//  ex_rs2_o       out   REG_AW source register 2 index
//  ex_rd_o        out   REG_AW destination index (0 when the instruction writes nothing)
//  ex_imm_o       out   XLEN   registered immediate
//  ex_ctrl_o      out   ex_ctrl_t  registered control bundle
//  hazard_stall_o out   1      combinational: load-use hazard is blocking acceptance
//  ex_illegal_o   out   1      registered illegal-opcode flag (DECODE_ILLEGAL_TRAP_EN only)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): every registered output = 0, including ex_valid_o, ex_ctrl_o, ex_illegal_o, and the internal load_pending flag.
//  - Decode is combinational on if_instr_i[6:0]:
//    - LOAD/OP-IMM/JALR -> IMM_I_TYPE; STORE -> S; BRANCH -> B; LUI/AUIPC -> U; JAL -> J; OP -> no immediate (imm=0).
//  - hazard = ex_valid_o & ex_ctrl_o.mem_re & (ex_rd_o!=0) & the incoming instruction reads that rd:
//    - rs1 is read by all types except U/J.
//    - rs2 is read by OP/STORE/BRANCH.
//  - if_ready_o = !flush_i & !hazard & (!ex_valid_o | ex_ready_i).
//  - Per cycle, priority order:
//    1. flush_i: ex_valid_o<=0; the IF/ID instruction is not accepted.
//    2. if_valid_i & if_ready_o: load the register, ex_valid_o<=1. Latency 1 cycle, IF accept -> EX visible.
//    3. ex_ready_i: ex_valid_o<=0 (bubble).
//    4. otherwise: hold every output stable.
//  - Load-use: a load in the register plus a dependent instruction in IF/ID gives exactly one bubble. The load leaves on ex_ready_i; the register empties; the dependent instruction is accepted the following cycle.
//  - Simultaneous hand-in and hand-out in the same cycle is full throughput (no bubble).
//  - ex_rd_o is forced to 0 for STORE/BRANCH.
//  - Payload outputs (pc/rs/rd/imm/ctrl) are don't-care while ex_valid_o=0. Verification checks them only when ex_valid_o=1.
//  - Reset mid-operation: all state cleared at once; if_ready_o resumes on the first cycle after rst_ni rises.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined:
//   - an unknown opcode, or any opcode with if_instr_i[1:0]!=2'b11, sets ex_illegal_o=1 alongside ex_valid_o;
//   - ex_ctrl_o is zeroed (no reg/mem write).
//  DECODE_ILLEGAL_TRAP_EN undefined:
//   - ex_illegal_o is tied to 0;
//   - unknown opcodes issue as a NOP: ctrl zero, rd=0, imm=0.
// STRUCTURE
//  - defs package: add opcode_t enum (RV32I major opcodes) and ex_ctrl_t packed struct {alu_op, alu_src_imm, reg_we, mem_re, mem_we, branch, jump}. imm_sel_t is already in defs.
//  - One sub-module: the existing ImmGen, instantiated combinationally (imm_sel_c from decode, imm_i = if_instr_i[31:7]). Its output is captured into ex_imm_o.
//  - Decode table, hazard compare and register stay in this module.
// TESTING
//  1. addi x1,x0,-1 (0xFFF00093), ex_ready_i=1 -> next cycle ex_valid_o=1, ex_imm_o=0xFFFFFFFF, ex_rd_o=1, reg_we=1.
//  2. sw x2,8(x3) (0x0021A423) -> ex_imm_o=8, ex_rd_o=0, mem_we=1, ex_rs1_o=3, ex_rs2_o=2.
//  3. lw x5,0(x1) (0x0000A283) then add x6,x5,x7 (0x00728333), ex_ready_i=1 throughout:
//     - hazard_stall_o=1 for one cycle;
//     - exactly one ex_valid_o=0 cycle between the two instructions.
//  4. ex_ready_i=0 for 3 cycles with if_valid_i=1 -> if_ready_o=0; ex_* outputs held bit-identical; no instruction lost or duplicated.
//  5. flush_i=1 with the register full and if_valid_i=1 -> next cycle ex_valid_o=0; if_ready_o=0 during flush; the load_pending hazard is cleared.
//  6. Instruction 0xFFFFFFFF:
//     - with DECODE_ILLEGAL_TRAP_EN: ex_illegal_o=1, ex_ctrl_o=0;
//     - without it: ex_illegal_o=0, issues as a NOP.
//     Assert rst_ni=0 mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode types for the ID stage: opcodes, immediate formats and the EX control bundle.
// Types and constants only; no latency and no flow control.
package decode_issue_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I_TYPE,
    IMM_S_TYPE,
    IMM_B_TYPE,
    IMM_U_TYPE,
    IMM_J_TYPE
  } imm_sel_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  // ALU_REG/ALU_IMM defer the exact operation to funct3/funct7 in EX.
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_REG,
    ALU_IMM,
    ALU_CMP,
    ALU_LUI,
    ALU_AUIPC
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    reg_we;
    logic    mem_re;
    logic    mem_we;
    logic    branch;
    logic    jump;
  } ex_ctrl_t;

endpackage

// File: rtl/decode_issue_ctrl_immgen.sv
// Immediate generator: reassembles and sign-extends the RV32I immediate from instr[31:7].
// Purely combinational, zero latency; no flow control.
module decode_issue_ctrl_immgen
  import decode_issue_ctrl_pkg::*;
(
  input  imm_sel_t          imm_sel,
  input  logic [24:0]       imm_i,
  output logic [XLEN-1:0]   imm_o
);

  // imm_i[k] holds instruction bit k+7.
  always_comb begin
    imm_o = '0;
    case (imm_sel)
      IMM_I_TYPE: imm_o = {{20{imm_i[24]}}, imm_i[24:13]};
      IMM_S_TYPE: imm_o = {{20{imm_i[24]}}, imm_i[24:18], imm_i[4:0]};
      IMM_B_TYPE: imm_o = {{19{imm_i[24]}}, imm_i[24], imm_i[0], imm_i[23:18], imm_i[4:1], 1'b0};
      IMM_U_TYPE: imm_o = {imm_i[24:5], 12'b0};
      IMM_J_TYPE: imm_o = {{11{imm_i[24]}}, imm_i[24], imm_i[12:5], imm_i[13], imm_i[23:14], 1'b0};
      default:    imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller between IF/ID and EX; DECODE_ILLEGAL_TRAP_EN enables the illegal-opcode flag.
// Latency 1 cycle from IF accept to EX visible; full throughput when EX drains in the same cycle.
// Backpressure: if_ready_o drops on flush, load-use hazard, or a full register EX is not taking.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [XLEN-1:0]   if_instr_i,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output ex_ctrl_t          ex_ctrl_o,
  output logic              hazard_stall_o,
  output logic              ex_illegal_o
);

  imm_sel_t          imm_sel_c;
  ex_ctrl_t          ctrl_c;
  logic              reads_rs1_c;
  logic              reads_rs2_c;
  logic [REG_AW-1:0] rs1_c;
  logic [REG_AW-1:0] rs2_c;
  logic [REG_AW-1:0] rd_c;
  logic [XLEN-1:0]   imm_c;
  logic              hazard_c;
  logic              accept_c;
  logic              load_pending_q;

  assign rs1_c = if_instr_i[19:15];
  assign rs2_c = if_instr_i[24:20];

  always_comb begin
    imm_sel_c   = IMM_NONE;
    ctrl_c      = '0;
    reads_rs1_c = 1'b0;
    reads_rs2_c = 1'b0;
    case (if_instr_i[6:0])
      OPC_LOAD: begin
        imm_sel_c = IMM_I_TYPE;
        ctrl_c.alu_src_imm = 1'b1; ctrl_c.reg_we = 1'b1; ctrl_c.mem_re = 1'b1;
        reads_rs1_c = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_sel_c = IMM_I_TYPE;
        ctrl_c.alu_op = ALU_IMM; ctrl_c.alu_src_imm = 1'b1; ctrl_c.reg_we = 1'b1;
        reads_rs1_c = 1'b1;
      end
      OPC_JALR: begin
        imm_sel_c = IMM_I_TYPE;
        ctrl_c.alu_src_imm = 1'b1; ctrl_c.reg_we = 1'b1; ctrl_c.jump = 1'b1;
        reads_rs1_c = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_c = IMM_S_TYPE;
        ctrl_c.alu_src_imm = 1'b1; ctrl_c.mem_we = 1'b1;
        reads_rs1_c = 1'b1; reads_rs2_c = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel_c = IMM_B_TYPE;
        ctrl_c.alu_op = ALU_CMP; ctrl_c.branch = 1'b1;
        reads_rs1_c = 1'b1; reads_rs2_c = 1'b1;
      end
      OPC_LUI: begin
        imm_sel_c = IMM_U_TYPE;
        ctrl_c.alu_op = ALU_LUI; ctrl_c.alu_src_imm = 1'b1; ctrl_c.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel_c = IMM_U_TYPE;
        ctrl_c.alu_op = ALU_AUIPC; ctrl_c.alu_src_imm = 1'b1; ctrl_c.reg_we = 1'b1;
      end
      OPC_JAL: begin
        imm_sel_c = IMM_J_TYPE;
        ctrl_c.reg_we = 1'b1; ctrl_c.jump = 1'b1;
      end
      OPC_OP: begin
        ctrl_c.alu_op = ALU_REG; ctrl_c.reg_we = 1'b1;
        reads_rs1_c = 1'b1; reads_rs2_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Instructions that write nothing (store, branch, unknown) carry rd=0.
  assign rd_c = ctrl_c.reg_we ? if_instr_i[11:7] : '0;

  decode_issue_ctrl_immgen u_immgen (
    .imm_sel (imm_sel_c),
    .imm_i   (if_instr_i[31:7]),
    .imm_o   (imm_c)
  );

  // load_pending_q already implies a valid load with a nonzero rd in the register.
  assign hazard_c = if_valid_i & load_pending_q &
                    ((reads_rs1_c & (rs1_c == ex_rd_o)) | (reads_rs2_c & (rs2_c == ex_rd_o)));

  assign hazard_stall_o = hazard_c;
  assign if_ready_o     = rst_ni & ~flush_i & ~hazard_c & (~ex_valid_o | ex_ready_i);
  assign accept_c       = if_valid_i & if_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_o     <= 1'b0;
      ex_pc_o        <= '0;
      ex_rs1_o       <= '0;
      ex_rs2_o       <= '0;
      ex_rd_o        <= '0;
      ex_imm_o       <= '0;
      ex_ctrl_o      <= '0;
      load_pending_q <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o     <= 1'b0;
      load_pending_q <= 1'b0;
    end else if (accept_c) begin
      ex_valid_o     <= 1'b1;
      ex_pc_o        <= if_pc_i;
      ex_rs1_o       <= rs1_c;
      ex_rs2_o       <= rs2_c;
      ex_rd_o        <= rd_c;
      ex_imm_o       <= imm_c;
      ex_ctrl_o      <= ctrl_c;
      load_pending_q <= ctrl_c.mem_re & (rd_c != '0);
    end else if (ex_ready_i) begin
      ex_valid_o     <= 1'b0;
      load_pending_q <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_c;

  // Every legal opcode ends in 2'b11 and selects an immediate, except OP.
  assign illegal_c = (if_instr_i[1:0] != 2'b11) |
                     ((imm_sel_c == IMM_NONE) & (if_instr_i[6:0] != OPC_OP));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_illegal_o <= 1'b0;
    end else if (flush_i) begin
      ex_illegal_o <= 1'b0;
    end else if (accept_c) begin
      ex_illegal_o <= illegal_c;
    end else if (ex_ready_i) begin
      ex_illegal_o <= 1'b0;
    end
  end
`else
  assign ex_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: transaction-level model with per-cycle compare plus directed literal checks.
module tb_decode_issue_ctrl;
  import decode_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, if_valid, if_ready, ex_valid, ex_ready, hazard, ex_illegal;
  logic [31:0] if_instr, if_pc, ex_pc, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  ex_ctrl_t    ex_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_issue_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .if_valid_i(if_valid), .if_ready_o(if_ready), .if_instr_i(if_instr), .if_pc_i(if_pc),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_pc_o(ex_pc),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_imm_o(ex_imm),
    .ex_ctrl_o(ex_ctrl), .hazard_stall_o(hazard), .ex_illegal_o(ex_illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    ex_ctrl_t    ctrl;
    logic        r1, r2, ill;
  } exp_t;

  exp_t q[$];  // contents of the ID->EX register as the model sees it

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = '0; e.imm = '0;
    e.ctrl = '0; e.r1 = 1'b0; e.r2 = 1'b0; e.ill = 1'b0;
    case (i[6:0])
      7'h03: begin e.imm = $signed(i) >>> 20; e.ctrl.alu_src_imm = 1; e.ctrl.reg_we = 1; e.ctrl.mem_re = 1; e.r1 = 1; end
      7'h13: begin e.imm = $signed(i) >>> 20; e.ctrl.alu_op = ALU_IMM; e.ctrl.alu_src_imm = 1; e.ctrl.reg_we = 1; e.r1 = 1; end
      7'h67: begin e.imm = $signed(i) >>> 20; e.ctrl.alu_src_imm = 1; e.ctrl.reg_we = 1; e.ctrl.jump = 1; e.r1 = 1; end
      7'h23: begin
        e.imm = (($signed(i) >>> 20) & 32'hFFFF_FFE0) | 32'(i[11:7]);
        e.ctrl.alu_src_imm = 1; e.ctrl.mem_we = 1; e.r1 = 1; e.r2 = 1;
      end
      7'h63: begin
        e.imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        e.ctrl.alu_op = ALU_CMP; e.ctrl.branch = 1; e.r1 = 1; e.r2 = 1;
      end
      7'h37: begin e.imm = i & 32'hFFFF_F000; e.ctrl.alu_op = ALU_LUI; e.ctrl.alu_src_imm = 1; e.ctrl.reg_we = 1; end
      7'h17: begin e.imm = i & 32'hFFFF_F000; e.ctrl.alu_op = ALU_AUIPC; e.ctrl.alu_src_imm = 1; e.ctrl.reg_we = 1; end
      7'h6F: begin
        e.imm = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        e.ctrl.reg_we = 1; e.ctrl.jump = 1;
      end
      7'h33: begin e.ctrl.alu_op = ALU_REG; e.ctrl.reg_we = 1; e.r1 = 1; e.r2 = 1; end
      default: e.ill = 1'b1;
    endcase
    if (e.ctrl.reg_we) e.rd = i[11:7];
`ifndef DECODE_ILLEGAL_TRAP_EN
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic m_hazard();
    exp_t d;
    if (q.size() == 0 || !if_valid) return 1'b0;
    d = model_decode(if_instr, if_pc);
    return q[0].ctrl.mem_re && q[0].rd != 0 &&
           ((d.r1 && d.rs1 == q[0].rd) || (d.r2 && d.rs2 == q[0].rd));
  endfunction

  function automatic logic m_ready();
    return rst_n && !flush && !m_hazard() && (q.size() == 0 || ex_ready);
  endfunction

  // Model state update, using pre-edge input values.
  always @(posedge clk) begin : model_update
    logic acc;
    exp_t n;
    if (rst_n) begin
      acc = if_valid && m_ready();
      n = model_decode(if_instr, if_pc);
      if (q.size() != 0 && (flush || ex_ready)) void'(q.pop_front());
      if (acc) q.push_back(n);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ex_valid", 32'(ex_valid), 32'(q.size() != 0));
      check("if_ready", 32'(if_ready), 32'(m_ready()));
      check("hazard", 32'(hazard), 32'(m_hazard()));
      if (q.size() != 0) begin
        check("ex_pc", ex_pc, q[0].pc);
        check("ex_rs1", 32'(ex_rs1), 32'(q[0].rs1));
        check("ex_rs2", 32'(ex_rs2), 32'(q[0].rs2));
        check("ex_rd", 32'(ex_rd), 32'(q[0].rd));
        check("ex_imm", ex_imm, q[0].imm);
        check("ex_ctrl", 32'(ex_ctrl), 32'(q[0].ctrl));
        check("ex_illegal", 32'(ex_illegal), 32'(q[0].ill));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Offer one instruction that must be taken on the next edge, then settle at the following negedge.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1; if_instr = instr; if_pc = pc;
    @(negedge clk);
    check("send_rdy", 32'(if_ready), 32'd1);
    cyc();
    if_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(ex_valid), 0);
    check({tag, "_pc"}, ex_pc, 0);
    check({tag, "_rs"}, 32'({ex_rs1, ex_rs2, ex_rd}), 0);
    check({tag, "_imm"}, ex_imm, 0);
    check({tag, "_ctrl"}, 32'(ex_ctrl), 0);
    check({tag, "_ill"}, 32'(ex_illegal), 0);
    check({tag, "_rdy"}, 32'(if_ready), 0);
    check({tag, "_haz"}, 32'(hazard), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b0;
    #1 check_all_zero("rst");
    @(negedge clk); rst_n = 1'b1;
    cyc();

    // addi x1,x0,-1
    ex_ready = 1'b1;
    send(32'hFFF00093, 32'h100);
    check("t1_valid", 32'(ex_valid), 1);
    check("t1_imm", ex_imm, 32'hFFFF_FFFF);
    check("t1_rd", 32'(ex_rd), 1);
    check("t1_we", 32'(ex_ctrl.reg_we), 1);

    // sw x2,8(x3)
    send(32'h0021A423, 32'h104);
    check("t2_imm", ex_imm, 8);
    check("t2_rd", 32'(ex_rd), 0);
    check("t2_mem_we", 32'(ex_ctrl.mem_we), 1);
    check("t2_rs1", 32'(ex_rs1), 3);
    check("t2_rs2", 32'(ex_rs2), 2);
    cyc();

    // lw x5,0(x1) then add x6,x5,x7: one stall, one bubble
    if_valid = 1'b1; if_instr = 32'h0000A283; if_pc = 32'h200;
    @(negedge clk); check("t3_lw_rdy", 32'(if_ready), 1);
    cyc(); if_instr = 32'h00728333; if_pc = 32'h204;
    @(negedge clk);
    check("t3_stall", 32'(hazard), 1);
    check("t3_rdy0", 32'(if_ready), 0);
    check("t3_lw_rd", 32'(ex_rd), 5);
    cyc();
    @(negedge clk);
    check("t3_bubble", 32'(ex_valid), 0);
    check("t3_nostall", 32'(hazard), 0);
    check("t3_rdy1", 32'(if_ready), 1);
    cyc(); if_valid = 1'b0;
    @(negedge clk);
    check("t3_add_valid", 32'(ex_valid), 1);
    check("t3_add_rd", 32'(ex_rd), 6);

    // EX stalls 3 cycles with lui waiting; then back-to-back drain/fill
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h12345537; if_pc = 32'h300;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_rdy0", 32'(if_ready), 0);
      check("t4_hold_pc", ex_pc, 32'h204);
      check("t4_hold_rd", 32'(ex_rd), 6);
      cyc();
    end
    ex_ready = 1'b1;
    @(negedge clk); check("t4_rdy1", 32'(if_ready), 1);
    cyc(); if_instr = 32'h008000EF; if_pc = 32'h304;
    @(negedge clk);
    check("t4_lui_pc", ex_pc, 32'h300);
    check("t4_lui_imm", ex_imm, 32'h1234_5000);
    check("t4_lui_rd", 32'(ex_rd), 10);
    cyc(); if_valid = 1'b0;
    @(negedge clk);
    check("t4_jal_imm", ex_imm, 8);
    check("t4_jal_jump", 32'(ex_ctrl.jump), 1);
    cyc();

    // flush with a load held and a dependent add waiting
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'h0000A283; if_pc = 32'h400;
    @(negedge clk); check("t5_lw_rdy", 32'(if_ready), 1);
    cyc(); if_instr = 32'h00728333; if_pc = 32'h404; flush = 1'b1;
    @(negedge clk); check("t5_rdy_flush", 32'(if_ready), 0);
    cyc(); flush = 1'b0;
    @(negedge clk);
    check("t5_killed", 32'(ex_valid), 0);
    check("t5_haz_clr", 32'(hazard), 0);
    check("t5_rdy_after", 32'(if_ready), 1);
    cyc(); if_valid = 1'b0;
    @(negedge clk); check("t5_add_pc", ex_pc, 32'h404);
    ex_ready = 1'b1;
    cyc();

    // all-ones instruction, then beq x1,x2,-4
    send(32'hFFFFFFFF, 32'h500);
    check("t6_ctrl", 32'(ex_ctrl), 0);
    check("t6_rd", 32'(ex_rd), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("t6_ill", 32'(ex_illegal), 1);
`else
    check("t6_ill", 32'(ex_illegal), 0);
    check("t6_imm", ex_imm, 0);
`endif
    send(32'hFE208EE3, 32'h504);
    check("t6_beq_imm", ex_imm, 32'hFFFF_FFFC);
    check("t6_beq_br", 32'(ex_ctrl.branch), 1);

    // asynchronous reset mid-stream
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'hFFF00093; if_pc = 32'h600;
    cyc(); #2;
    rst_n = 1'b0; q.delete();
    #1 check_all_zero("mid_rst");
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); check("rst_resume_rdy", 32'(if_ready), 1);
    cyc(); if_valid = 1'b0;
    @(negedge clk); check("rst_resume_pc", ex_pc, 32'h600);
    ex_ready = 1'b1;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
